// File: rtl/cpu_oci_dct_capture_if.sv
// DCT capture bus: trace word input from the OCI plus the valid/ready read port.
// master drives trace words and rd_ready; slave is the capture block.
interface cpu_oci_dct_capture_if #(
   parameter int FRAME_W = 2,
   parameter int FRAMES  = 15,
   parameter int CNT_W   = 4
);
   logic                             dct_valid;
   logic [FRAME_W*FRAMES-1:0]        dct_buffer;
   logic [CNT_W-1:0]                 dct_count;
   logic                             rd_valid;
   logic                             rd_ready;
   logic [CNT_W+FRAME_W*FRAMES-1:0]  rd_data;

   modport master (
      output dct_valid, dct_buffer, dct_count, rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  dct_valid, dct_buffer, dct_count, rd_ready,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/cpu_oci_dct_capture.sv
// Captures {dct_count, dct_buffer} trace words into a FIFO and offers them on a
// registered first-word-fall-through read port. Sequencing of the test end:
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | after reset, trace ignored until arm
//   CAPTURE  | accepting trace words
//   DRAIN    | test_ending seen, waiting for FIFO empty and test end
//   DONE     | everything drained and test has ended; arm restarts
module cpu_oci_dct_capture #(
   parameter int FRAME_W = 2,
   parameter int FRAMES  = 15,
   parameter int CNT_W   = 4,
   parameter int DEPTH   = 16,
   parameter int OVF_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    arm,
   input  logic                    test_ending,
   input  logic                    test_has_ended,
   cpu_oci_dct_capture_if.slave    bus,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [OVF_W-1:0]        overflow_cnt,
   output logic                    bad_count,
   output logic [1:0]              state,
   output logic                    done
);
   localparam int DW = FRAME_W*FRAMES;
   localparam int EW = CNT_W+DW;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW+1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_CAPTURE = 2'b01,
      ST_DRAIN   = 2'b10,
      ST_DONE    = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              ended_q;
   logic [LW-1:0]     level_q;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_next;
   logic [EW-1:0]     mem [DEPTH];
   logic              rd_valid_q, rd_valid_d;
   logic [EW-1:0]     rd_data_q, rd_data_d;
   logic [OVF_W-1:0]  ovf_q;
   logic              bad_q;

   logic              count_ok, push_req, pop, full, push, drop_full, bad_word;
   logic [LW-1:0]     level_after_pop;

   assign count_ok  = (bus.dct_count != '0) && (bus.dct_count <= CNT_W'(FRAMES));
   assign push_req  = bus.dct_valid && (state_q == ST_CAPTURE);
   assign bad_word  = push_req && !count_ok;
   assign pop       = rd_valid_q && bus.rd_ready;
   assign full      = (level_q == LW'(DEPTH));
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push      = push_req && count_ok && (!full || pop);
   assign drop_full = push_req && count_ok && full && !pop;

   // The read register looks at the level before this cycle's push, which gives
   // the one-cycle fall-through latency and no bubble between back-to-back pops.
   assign level_after_pop = level_q - LW'(pop);
   assign rd_ptr_next     = rd_ptr_q + AW'(pop);
   assign rd_valid_d      = (level_after_pop != '0);
   assign rd_data_d       = rd_valid_d ? mem[rd_ptr_next] : '0;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (arm) state_d = ST_CAPTURE;
         ST_CAPTURE: if (test_ending) state_d = ST_DRAIN;
         ST_DRAIN:   if ((level_q == '0) && ended_q) state_d = ST_DONE;
         ST_DONE:    if (arm) state_d = ST_CAPTURE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Ended flag and sticky error/overflow counters; arm starts a fresh run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ended_q <= 1'b0;
         ovf_q   <= '0;
         bad_q   <= 1'b0;
      end else if (arm) begin
         ended_q <= 1'b0;
         ovf_q   <= '0;
         bad_q   <= 1'b0;
      end else begin
         if (test_has_ended && (state_q != ST_IDLE)) ended_q <= 1'b1;
         if (bad_word) bad_q <= 1'b1;
         if (drop_full && (ovf_q != '1)) ovf_q <= ovf_q + OVF_W'(1);
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         rd_ptr_q <= rd_ptr_next;
         if (push && !pop)      level_q <= level_q + LW'(1);
         else if (pop && !push) level_q <= level_q - LW'(1);
      end
   end

   // Registered head of FIFO; zero whenever nothing is offered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage array, contents not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {bus.dct_count, bus.dct_buffer};
   end

   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;
   assign fifo_level    = level_q;
   assign overflow_cnt  = ovf_q;
   assign bad_count     = bad_q;
   assign state         = state_q;
   assign done          = (state_q == ST_DONE);
endmodule

// File: tb/tb_cpu_oci_dct_capture.sv
// Directed bench for cpu_oci_dct_capture: stimulus pushes expected read words
// into a queue, a negedge monitor pops and compares every read handshake.
module tb_cpu_oci_dct_capture;
   logic clk = 1'b0;
   logic reset, arm, test_ending, test_has_ended;

   logic [4:0]  fifo_level, fifo_level2;
   logic [15:0] overflow_cnt, overflow_cnt2;
   logic        bad_count, bad_count2;
   logic [1:0]  state, state2;
   logic        done, done2;

   cpu_oci_dct_capture_if #(.FRAME_W(2), .FRAMES(15), .CNT_W(4)) bus ();
   cpu_oci_dct_capture_if #(.FRAME_W(2), .FRAMES(14), .CNT_W(4)) bus2 ();

   cpu_oci_dct_capture #(.FRAME_W(2), .FRAMES(15), .CNT_W(4), .DEPTH(16), .OVF_W(16)) dut (
      .clk(clk), .reset(reset), .arm(arm), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .bus(bus), .fifo_level(fifo_level),
      .overflow_cnt(overflow_cnt), .bad_count(bad_count), .state(state), .done(done)
   );

   cpu_oci_dct_capture #(.FRAME_W(2), .FRAMES(14), .CNT_W(4), .DEPTH(16), .OVF_W(16)) dut2 (
      .clk(clk), .reset(reset), .arm(arm), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .bus(bus2), .fifo_level(fifo_level2),
      .overflow_cnt(overflow_cnt2), .bad_count(bad_count2), .state(state2), .done(done2)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [33:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_word(input logic [3:0] cnt, input logic [29:0] data, input bit expect_out);
      bus.dct_valid  = 1'b1;
      bus.dct_count  = cnt;
      bus.dct_buffer = data;
      if (expect_out) exp_q.push_back({cnt, data});
      tick();
   endtask

   task automatic idle_input();
      bus.dct_valid  = 1'b0;
      bus.dct_count  = '0;
      bus.dct_buffer = '0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 80; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk(name, exp_q.size(), 0);
   endtask

   // Monitor: every handshake pops the scoreboard; idle read port must show zero data.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rd_valid) begin
            if (bus.rd_ready) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL rd_unexpected got=%0h exp=none", bus.rd_data);
               end else begin
                  logic [33:0] e;
                  e = exp_q.pop_front();
                  if (bus.rd_data !== e) begin
                     fails++;
                     $display("FAIL rd_data got=%0h exp=%0h", bus.rd_data, e);
                  end
               end
            end
         end else begin
            tests++;
            if (bus.rd_data !== '0) begin
               fails++;
               $display("FAIL rd_data_idle got=%0h exp=0", bus.rd_data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      reset = 1'b1; arm = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
      idle_input();
      bus.rd_ready   = 1'b0;
      bus2.dct_valid = 1'b0; bus2.dct_count = '0; bus2.dct_buffer = '0; bus2.rd_ready = 1'b0;

      #12;
      chk("rst_level", fifo_level, 0);
      chk("rst_state", state, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_ovf", overflow_cnt, 0);
      chk("rst_bad", bad_count, 0);
      chk("rst_done", done, 0);
      tick();
      reset = 1'b0;
      tick();

      // 1: three words, first one visible one cycle after its push
      bus.rd_ready = 1'b1;
      pulse_arm();
      chk("t1_state_capture", state, 2'b01);
      drive_word(4'hF, 30'h1, 1);
      chk("t1_not_yet_valid", bus.rd_valid, 0);
      drive_word(4'hF, 30'h2, 1);
      chk("t1_first_valid", bus.rd_valid, 1);
      chk("t1_first_data", bus.rd_data, {4'hF, 30'h1});
      drive_word(4'hF, 30'h3, 1);
      idle_input();
      wait_empty("t1_drain");
      tick();
      chk("t1_level0", fifo_level, 0);

      // 2: fill past capacity with no reader
      bus.rd_ready = 1'b0;
      for (int i = 0; i < 18; i++) drive_word(4'hF, 30'h100 + 30'(i), i < 16);
      idle_input();
      tick();
      chk("t2_level_full", fifo_level, 16);
      chk("t2_ovf", overflow_cnt, 2);
      chk("t2_head_stable", bus.rd_data, {4'hF, 30'h100});

      // 3: push and pop together while full
      bus.rd_ready = 1'b1;
      drive_word(4'hF, 30'h3AA, 1);
      bus.rd_ready = 1'b0;
      idle_input();
      chk("t3_level_full", fifo_level, 16);
      chk("t3_ovf_same", overflow_cnt, 2);
      bus.rd_ready = 1'b1;
      wait_empty("t3_drain");
      tick();
      chk("t3_level0", fifo_level, 0);
      chk("t3_rd_valid0", bus.rd_valid, 0);

      // 4: invalid counts are dropped and flagged
      drive_word(4'h0, 30'h55, 0);
      idle_input();
      tick();
      chk("t4_bad", bad_count, 1);
      chk("t4_level0", fifo_level, 0);
      chk("t4_ovf_untouched", overflow_cnt, 2);
      bus2.dct_valid = 1'b1; bus2.dct_count = 4'hF; bus2.dct_buffer = 28'h77;
      tick();
      bus2.dct_valid = 1'b0;
      tick();
      chk("t4_bad_gt_frames", bad_count2, 1);
      chk("t4_level2_0", fifo_level2, 0);
      bus2.dct_valid = 1'b1; bus2.dct_count = 4'hE; bus2.dct_buffer = 28'h78;
      tick();
      bus2.dct_valid = 1'b0;
      chk("t4_level2_max_count", fifo_level2, 1);

      // 5: end-of-test sequencing
      pulse_arm();
      chk("t5_arm_ovf0", overflow_cnt, 0);
      chk("t5_arm_bad0", bad_count, 0);
      bus.rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_word(4'h5, 30'h200 + 30'(i), 1);
      drive_word(4'h0, 30'h0, 0);
      idle_input();
      test_has_ended = 1'b1;
      tick();
      test_has_ended = 1'b0;
      chk("t5_still_capture", state, 2'b01);
      test_ending = 1'b1;
      tick();
      test_ending = 1'b0;
      chk("t5_state_drain", state, 2'b10);
      drive_word(4'h5, 30'h2FF, 0);
      idle_input();
      chk("t5_drain_ignores", fifo_level, 4);
      bus.rd_ready = 1'b1;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick();
         if (fifo_level == 0) hit = 1;
      end
      chk("t5_level_hit0", hit, 1);
      chk("t5_drain_hold", state, 2'b10);
      chk("t5_done_not_yet", done, 0);
      tick();
      chk("t5_state_done", state, 2'b11);
      chk("t5_done", done, 1);
      chk("t5_bad_before_arm", bad_count, 1);
      chk("t5_sb_empty", exp_q.size(), 0);
      pulse_arm();
      chk("t5_rearm_state", state, 2'b01);
      chk("t5_rearm_bad0", bad_count, 0);
      chk("t5_rearm_ovf0", overflow_cnt, 0);
      chk("t5_rearm_done0", done, 0);

      // 6: asynchronous reset in the middle of a burst
      bus.rd_ready = 1'b0;
      for (int i = 0; i < 7; i++) drive_word(4'h3, 30'h300 + 30'(i), 0);
      chk("t6_level7", fifo_level, 7);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_level", fifo_level, 0);
      chk("t6_rst_state", state, 0);
      chk("t6_rst_rd_valid", bus.rd_valid, 0);
      chk("t6_rst_rd_data", bus.rd_data, 0);
      chk("t6_rst_done", done, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("t6_ignored_level", fifo_level, 0);
      chk("t6_ignored_state", state, 0);
      idle_input();
      pulse_arm();
      bus.rd_ready = 1'b1;
      drive_word(4'h7, 30'h2A, 1);
      idle_input();
      wait_empty("t6_restart");
      tick();
      chk("t6_final_level", fifo_level, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
